// File: rtl/matmul_job_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_job_ctrl
//
// Job sequencer for the matmul core and its x, y and z BRAMs. One job:
//   1. accept MATRIX_WORDS x words, then MATRIX_WORDS y words (valid/ready),
//      writing each accepted word straight into the matching BRAM write port;
//   2. pulse mm_start for one cycle and wait for mm_done;
//   3. read z out of the z BRAM (1-cycle read latency) through a 2-entry
//      output buffer and present it on a valid/ready result stream.
//
// Ports
//   clock, reset          : single clock; synchronous active-high reset
//   in_data/valid/ready   : operand stream (x words, then y words, row-major)
//   x_din/x_wr_addr/x_wr_en, y_din/y_wr_addr/y_wr_en : BRAM write ports
//   mm_start (pulse), mm_done (level)                : matmul core control
//   z_addr, z_dout        : z BRAM read port, data valid 1 cycle after address
//   out_data/valid/ready  : result stream
//   busy                  : low only when idle (LOAD_X with no word taken)
//   job_done              : 1-cycle pulse when the last z word is accepted
// -----------------------------------------------------------------------------
module matmul_job_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int VECTOR_SIZE = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic [ADDR_WIDTH-1:0] x_wr_addr,
  output logic                  x_wr_en,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic [ADDR_WIDTH-1:0] y_wr_addr,
  output logic                  y_wr_en,
  output logic                  mm_start,
  input  logic                  mm_done,
  output logic [ADDR_WIDTH-1:0] z_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  job_done
);

  localparam int MATRIX_WORDS = VECTOR_SIZE * VECTOR_SIZE;
  // The read counter must be able to hold MATRIX_WORDS itself ("all issued").
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MATRIX_WORDS - 1);
  localparam logic [CNT_W-1:0]      WORDS_CNT = CNT_W'(MATRIX_WORDS);

  if (MATRIX_WORDS > (2 ** ADDR_WIDTH)) begin : g_size_check
    $error("matmul_job_ctrl: VECTOR_SIZE*VECTOR_SIZE does not fit in ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    S_LOAD_X,
    S_LOAD_Y,
    S_RUN,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;       // operand words taken in this phase
  logic [CNT_W-1:0]      rcnt_q, rcnt_d;       // z reads issued
  logic [ADDR_WIDTH-1:0] ocnt_q, ocnt_d;       // result words accepted downstream
  logic                  armed_q, armed_d;     // first WAIT cycle already spent
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;         // output buffer occupancy 0..2
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] obuf_q [2];
  logic [DATA_WIDTH-1:0] obuf_d [2];

  logic       pop;
  logic       issue;
  logic [2:0] fill;

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == S_LOAD_X) || (state_q == S_LOAD_Y);

  assign x_wr_en   = (state_q == S_LOAD_X) && in_valid;
  assign x_din     = in_data;
  assign x_wr_addr = wcnt_q;
  assign y_wr_en   = (state_q == S_LOAD_Y) && in_valid;
  assign y_din     = in_data;
  assign y_wr_addr = wcnt_q;

  assign mm_start  = (state_q == S_RUN);

  // Address follows the read counter, so it holds whenever nothing is issued.
  assign z_addr    = rcnt_q[ADDR_WIDTH-1:0];

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = obuf_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;

  assign busy      = !((state_q == S_LOAD_X) && (wcnt_q == '0));
  assign job_done  = pop && (ocnt_q == LAST_ADDR);

  // A read may only be issued if its data is guaranteed a buffer slot when it
  // returns next cycle: words held + word in flight - word leaving now < 2.
  assign fill  = {1'b0, occ_q} + {2'b00, inflight_q};
  assign issue = (state_q == S_DRAIN) && (rcnt_q < WORDS_CNT) &&
                 (fill < (3'd2 + {2'b00, pop}));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every next-state variable gets its current value first, so no path
    // through the case statement leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    ocnt_d     = ocnt_q;
    armed_d    = armed_q;
    inflight_d = issue;
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    obuf_d     = obuf_q;

    if (issue) begin
      rcnt_d = rcnt_q + CNT_W'(1);
    end

    // Read data returning from last cycle's issue lands in the buffer.
    if (inflight_q) begin
      obuf_d[wr_ptr_q] = z_dout;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      ocnt_d   = ocnt_q + ADDR_WIDTH'(1);
    end

    case (state_q)
      S_LOAD_X: begin
        if (in_valid) begin
          if (wcnt_q == LAST_ADDR) begin
            wcnt_d  = '0;
            state_d = S_LOAD_Y;
          end else begin
            wcnt_d = wcnt_q + ADDR_WIDTH'(1);
          end
        end
      end

      S_LOAD_Y: begin
        if (in_valid) begin
          if (wcnt_q == LAST_ADDR) begin
            wcnt_d  = '0;
            state_d = S_RUN;
          end else begin
            wcnt_d = wcnt_q + ADDR_WIDTH'(1);
          end
        end
      end

      S_RUN: begin
        armed_d = 1'b0;
        state_d = S_WAIT;
      end

      // mm_done can still be high from the previous job during the first WAIT
      // cycle, so it is only honoured once armed_q is set.
      S_WAIT: begin
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (mm_done) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (job_done) begin
          state_d    = S_LOAD_X;
          rcnt_d     = '0;
          ocnt_d     = '0;
          occ_d      = '0;
          inflight_d = 1'b0;
          rd_ptr_d   = 1'b0;
          wr_ptr_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_LOAD_X;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values from the combinational block, whatever the order here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_LOAD_X;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      ocnt_q     <= '0;
      armed_q    <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      ocnt_q     <= ocnt_d;
      armed_q    <= armed_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: the buffer storage is deliberately not reset; occ_q gates out_valid,
  // so stale contents are never observable and the data flops stay plain.
  always_ff @(posedge clock) begin
    obuf_q <= obuf_d;
  end

endmodule

// File: tb/tb_matmul_job_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_job_ctrl
//
// Drives matmul_job_ctrl (VECTOR_SIZE=4, 16-word matrices) against behavioural
// x/y/z BRAMs and a matmul core with a fixed latency that leaves mm_done high
// between jobs. A small vector table covers reset and the first load beats;
// run_jobs() streams whole jobs and checks every cycle against expectations
// derived from the bench's own job bookkeeping.
// -----------------------------------------------------------------------------
module tb_matmul_job_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int VS  = 4;
  localparam int MW  = VS * VS;
  localparam int LAT = 5;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic [DW-1:0] in_data   = '0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic          mm_done   = 1'b0;
  logic [DW-1:0] z_dout    = '0;

  logic          in_ready;
  logic [DW-1:0] x_din, y_din, out_data;
  logic [AW-1:0] x_wr_addr, y_wr_addr, z_addr;
  logic          x_wr_en, y_wr_en, mm_start, out_valid, busy, job_done;

  matmul_job_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .VECTOR_SIZE(VS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_din    (x_din),
    .x_wr_addr(x_wr_addr),
    .x_wr_en  (x_wr_en),
    .y_din    (y_din),
    .y_wr_addr(y_wr_addr),
    .y_wr_en  (y_wr_en),
    .mm_start (mm_start),
    .mm_done  (mm_done),
    .z_addr   (z_addr),
    .z_dout   (z_dout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .job_done (job_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Behavioural BRAMs and matmul core
  // ---------------------------------------------------------------------------
  logic [DW-1:0] x_mem [MW];
  logic [DW-1:0] y_mem [MW];
  logic [DW-1:0] z_mem [MW];
  int            m_cnt = 0;

  function automatic logic [DW-1:0] mat_elem(input logic [DW-1:0] a [MW],
                                             input logic [DW-1:0] b [MW],
                                             input int idx);
    logic [DW-1:0] acc;
    int r, c;
    acc = '0;
    r   = idx / VS;
    c   = idx % VS;
    for (int k = 0; k < VS; k++) acc += a[r*VS+k] * b[k*VS+c];
    return acc;
  endfunction

  initial begin
    for (int i = 0; i < MW; i++) begin
      x_mem[i] = '0;
      y_mem[i] = '0;
      z_mem[i] = '0;
    end
  end

  // done keeps its old level for the cycle after start, then drops until the
  // product is ready, then stays high until the next job.
  always @(posedge clock) begin
    z_dout <= z_mem[z_addr[3:0]];
    if (x_wr_en) x_mem[x_wr_addr[3:0]] <= x_din;
    if (y_wr_en) y_mem[y_wr_addr[3:0]] <= y_din;
    if (mm_start) begin
      m_cnt <= LAT;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mm_done <= 1'b1;
        for (int i = 0; i < MW; i++) z_mem[i] <= mat_elem(x_mem, y_mem, i);
      end else begin
        mm_done <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, want, $time);
    end
  endtask

  // Job data slots and expected products.
  logic [DW-1:0] jx [2][MW];
  logic [DW-1:0] jy [2][MW];
  logic [DW-1:0] jz [2][MW];

  // seed 0: x = 1..16, y = identity; other seeds: small pseudo-random values.
  task automatic fill_job(input int s, input int seed);
    logic [DW-1:0] tx [MW];
    logic [DW-1:0] ty [MW];
    for (int i = 0; i < MW; i++) begin
      if (seed == 0) begin
        tx[i] = 32'(i + 1);
        ty[i] = ((i / VS) == (i % VS)) ? 32'd1 : 32'd0;
      end else begin
        tx[i] = 32'((seed * 7 + i * 3) % 50 + 1);
        ty[i] = 32'((seed * 5 + i * 11) % 37);
      end
      jx[s][i] = tx[i];
      jy[s][i] = ty[i];
    end
    for (int i = 0; i < MW; i++) jz[s][i] = mat_elem(tx, ty, i);
  endtask

  // Reset for one edge, then verify the idle state for a few cycles.
  task automatic do_reset(input string tag);
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check({tag, "/in_ready"},  32'(in_ready),  32'd1);
    check({tag, "/busy"},      32'(busy),      32'd0);
    check({tag, "/out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "/mm_start"},  32'(mm_start),  32'd0);
    check({tag, "/job_done"},  32'(job_done),  32'd0);
    check({tag, "/z_addr"},    32'(z_addr),    32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check({tag, "/quiet_start"}, 32'(mm_start),  32'd0);
      check({tag, "/quiet_valid"}, 32'(out_valid), 32'd0);
    end
  endtask

  // Streams njobs jobs from slots 0..njobs-1 and checks every cycle.
  //   in_mode 0: in_valid high whenever a word is pending (next job's first
  //              word is held while the controller is not ready);
  //   in_mode 1: in_valid only on even cycles.
  //   out_mode 0: out_ready always high; 1: low 5 cycles at word 3, then random.
  //   abort_sent / abort_recv > 0: return once that many words were taken / accepted.
  task automatic run_jobs(input int njobs, input int in_mode, input int out_mode,
                          input int abort_sent, input int abort_recv);
    int            job        = 0;
    int            sent       = 0;
    int            recv       = 0;
    int            load_cyc   = -1;
    int            rise_cyc   = -1;
    int            stall_left = 5;
    int            budget     = 0;
    bit            started    = 1'b0;
    bit            prev_done  = 1'b0;
    bit            prev_stall = 1'b0;
    bit            exp_ready, beat;
    logic [DW-1:0] prev_data  = '0;
    string         pfx;

    while (job < njobs && budget < 1000) begin
      @(negedge clock);
      if (sent < 32) begin
        in_valid = (in_mode == 0) || (cyc % 2 == 0);
        in_data  = (sent < 16) ? jx[job][sent] : jy[job][sent-16];
      end else if (job + 1 < njobs) begin
        in_valid = 1'b1;
        in_data  = jx[job+1][0];
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      if (out_mode == 0) begin
        out_ready = 1'b1;
      end else if (recv == 3 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      #1;
      pfx = $sformatf("j%0d", job);

      exp_ready = (sent < 32);
      beat      = in_valid && exp_ready;
      check({pfx, "/in_ready"}, 32'(in_ready), 32'(exp_ready));
      check({pfx, "/x_wr_en"},  32'(x_wr_en),  32'(beat && sent < 16));
      check({pfx, "/y_wr_en"},  32'(y_wr_en),  32'(beat && sent >= 16));
      if (beat && sent < 16) begin
        check({pfx, "/x_wr_addr"}, 32'(x_wr_addr), 32'(sent));
        check({pfx, "/x_din"},     x_din,          jx[job][sent]);
      end
      if (beat && sent >= 16) begin
        check({pfx, "/y_wr_addr"}, 32'(y_wr_addr), 32'(sent - 16));
        check({pfx, "/y_din"},     y_din,          jy[job][sent-16]);
      end
      check({pfx, "/mm_start"}, 32'(mm_start), 32'(load_cyc >= 0 && cyc == load_cyc + 1));
      check({pfx, "/busy"},     32'(busy),     32'(sent != 0));
      if (mm_start) started = 1'b1;

      if (started && mm_done && !prev_done && rise_cyc < 0) rise_cyc = cyc;
      prev_done = mm_done;

      if (prev_stall) begin
        check({pfx, "/hold_valid"}, 32'(out_valid), 32'd1);
        check({pfx, "/hold_data"},  out_data,       prev_data);
      end
      if (rise_cyc < 0 || cyc < rise_cyc + 3) begin
        check({pfx, "/early_valid"}, 32'(out_valid), 32'd0);
      end else if (cyc == rise_cyc + 3) begin
        check({pfx, "/first_valid"}, 32'(out_valid), 32'd1);
      end
      if (started) begin
        check({pfx, "/z_ahead"}, 32'((int'(z_addr) - recv) <= 2), 32'd1);
      end

      if (out_valid && out_ready) begin
        check($sformatf("%s/out_data[%0d]", pfx, recv), out_data, jz[job][recv]);
        check({pfx, "/job_done"}, 32'(job_done), 32'(recv == MW - 1));
        if (out_mode == 0 && recv == MW - 1) begin
          check({pfx, "/last_cycle"}, 32'(cyc), 32'(rise_cyc + 3 + MW - 1));
        end
        recv++;
      end else begin
        check({pfx, "/job_done_idle"}, 32'(job_done), 32'd0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;

      if (beat) begin
        sent++;
        if (sent == 32) load_cyc = cyc;
      end
      if (abort_sent > 0 && sent == abort_sent) return;
      if (abort_recv > 0 && recv == abort_recv) return;

      if (recv == MW) begin
        job++;
        sent       = 0;
        recv       = 0;
        load_cyc   = -1;
        rise_cyc   = -1;
        started    = 1'b0;
        stall_left = 5;
        prev_stall = 1'b0;
      end
      budget++;
    end
    if (job < njobs) check("job_timeout", 32'd0, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: reset state and first LOAD_X beats
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          iv;
    logic [DW-1:0] din;
    logic          en;
    logic [AW-1:0] addr;
    logic          busy;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{iv: 1'b0, din: 32'h0,  en: 1'b0, addr: 12'd0, busy: 1'b0};
    vecs[1] = '{iv: 1'b1, din: 32'hA5, en: 1'b1, addr: 12'd0, busy: 1'b0};
    vecs[2] = '{iv: 1'b0, din: 32'h0,  en: 1'b0, addr: 12'd1, busy: 1'b1};
    vecs[3] = '{iv: 1'b1, din: 32'hB6, en: 1'b1, addr: 12'd1, busy: 1'b1};
    vecs[4] = '{iv: 1'b1, din: 32'hC7, en: 1'b1, addr: 12'd2, busy: 1'b1};

    repeat (2) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      reset    = 1'b0;
      in_valid = vecs[i].iv;
      in_data  = vecs[i].din;
      #1;
      check($sformatf("vec%0d/x_wr_en", i),   32'(x_wr_en),   32'(vecs[i].en));
      check($sformatf("vec%0d/x_wr_addr", i), 32'(x_wr_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d/busy", i),      32'(busy),      32'(vecs[i].busy));
      check($sformatf("vec%0d/in_ready", i),  32'(in_ready),  32'd1);
      check($sformatf("vec%0d/y_wr_en", i),   32'(y_wr_en),   32'd0);
      check($sformatf("vec%0d/mm_start", i),  32'(mm_start),  32'd0);
      check($sformatf("vec%0d/out_valid", i), 32'(out_valid), 32'd0);
      if (vecs[i].en) check($sformatf("vec%0d/x_din", i), x_din, vecs[i].din);
      if (i == 0) begin
        check("vec0/job_done", 32'(job_done), 32'd0);
        check("vec0/z_addr",   32'(z_addr),   32'd0);
      end
    end
    do_reset("rst_idle");

    // Full job without stalls: x = 1..16, y = identity.
    fill_job(0, 0);
    run_jobs(1, 0, 0, 0, 0);

    // Same data with input bubbles; mm_done is still high from the last job.
    run_jobs(1, 1, 0, 0, 0);

    // Output backpressure with a general product.
    fill_job(0, 1);
    run_jobs(1, 0, 1, 0, 0);

    // Reset while presenting y word 7, then again at z word 9.
    fill_job(0, 2);
    run_jobs(1, 0, 0, 23, 0);
    do_reset("rst_y7");
    run_jobs(1, 0, 0, 0, 9);
    do_reset("rst_z9");

    // Fresh complete job after the aborted attempts.
    run_jobs(1, 0, 0, 0, 0);

    // Two jobs streamed back to back.
    fill_job(0, 3);
    fill_job(1, 4);
    run_jobs(2, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_job_ctrl.md
Name: matmul_job_ctrl

Overview:
Job sequencer for the matmul core and its three BRAMs (x, y, z). It takes one operand stream: MATRIX_WORDS words of x followed by MATRIX_WORDS words of y, using a valid/ready handshake. It writes those words into the x and y BRAM write ports, pulses the core's start, and waits for done. It then reads z out of the z BRAM read port and presents it on a valid/ready output stream. It sits between the host interface and the matmul top level and drives every external port of the top level except clock and reset.

Parameters:
DATA_WIDTH, 32, word width of operands and results
ADDR_WIDTH, 12, BRAM address width
VECTOR_SIZE, 64, matrix dimension; MATRIX_WORDS = VECTOR_SIZE*VECTOR_SIZE; elaboration error if MATRIX_WORDS > 2**ADDR_WIDTH

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_data  in  DATA_WIDTH  operand word (x words, then y words, row-major)
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts in_data
x_din  out  DATA_WIDTH  x BRAM write data
x_wr_addr  out  ADDR_WIDTH  x BRAM write address
x_wr_en  out  1  x BRAM write enable
y_din  out  DATA_WIDTH  y BRAM write data
y_wr_addr  out  ADDR_WIDTH  y BRAM write address
y_wr_en  out  1  y BRAM write enable
mm_start  out  1  one-cycle start pulse to the matmul core
mm_done  in  1  matmul core done (level)
z_addr  out  ADDR_WIDTH  z BRAM read address
z_dout  in  DATA_WIDTH  z BRAM read data, valid 1 cycle after z_addr is sampled
out_data  out  DATA_WIDTH  result word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
busy  out  1  high in every state except LOAD_X with word count 0
job_done  out  1  one-cycle pulse when the last z word is accepted

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high; it is decided and not configurable.
- State after reset: state=LOAD_X, all counters 0, output buffer empty.
- Output values after reset: in_ready=1; mm_start, all wr_en, out_valid, job_done and busy are 0; z_addr=0.
- Reset mid-job: same result as a reset from idle. The partial load or drain is discarded, the buffer is flushed, and no start is issued.
- Handshakes: a beat transfers when valid & ready are both high on a clock edge. in_data may change only after its beat transfers. out_data/out_valid are held stable while out_valid=1 and out_ready=0.
- LOAD_X state:
  - in_ready=1.
  - x_wr_en = in_valid (combinational), with x_din=in_data and x_wr_addr=wcnt.
  - wcnt increments on each beat. The beat with wcnt=MATRIX_WORDS-1 sets wcnt to 0 and moves to LOAD_Y.
- LOAD_Y state: same as LOAD_X but drives the y write port, and the last beat moves to RUN.
- RUN state (1 cycle): in_ready=0, mm_start=1, then move to WAIT. Start is therefore asserted the cycle after the last y write commits.
- WAIT state:
  - mm_done is ignored in the first WAIT cycle, because done may still be high from the previous job.
  - After that, mm_done=1 moves to DRAIN.
- DRAIN state:
  - Read issue: issue = (occ + inflight - pop) < 2 and rcnt < MATRIX_WORDS, where occ is output buffer occupancy (0..2), inflight is the registered issue flag from the previous cycle, and pop = out_valid & out_ready.
  - z_addr = rcnt[ADDR_WIDTH-1:0], driven combinationally. rcnt increments on issue.
  - Capture: z_dout is written into the buffer in the cycle after an issue.
  - Output: out_valid = (occ > 0) and out_data = buffer head. The buffer is a 2-entry FIFO, so it never overflows.
  - Latency: the first out_valid appears 2 cycles after DRAIN entry. With out_ready held high, throughput is one word per cycle.
  - Completion: when the beat for word MATRIX_WORDS-1 is accepted, job_done=1 for one cycle, state returns to LOAD_X and all counters clear.
- Back-to-back jobs: in_ready rises the cycle after job_done. No in_data is accepted during RUN, WAIT or DRAIN.
- z_addr holds its last value when no read is issued.
- The wr_en outputs never assert outside their LOAD states. x and y are never written in the same cycle.

Test Plan:
- Parameter setting for all scenarios: VECTOR_SIZE=4 (MATRIX_WORDS=16) with a behavioural matmul model.
- Full job, no stalls: in_valid constantly high with x=1..16 and y=identity. Expect:
  - 16 x writes at addresses 0..15, then 16 y writes.
  - mm_start high exactly 1 cycle, the cycle after the 32nd beat.
  - out stream = 1..16 in order, in 16 consecutive cycles, starting 2 cycles after DRAIN entry.
  - job_done pulses once with the 16th output.
- Input bubbles: in_valid toggles every other cycle. Expect wr_en only on handshake cycles, write addresses still contiguous 0..15, and results identical to the full-job case.
- Output backpressure: out_ready low for 5 cycles at result word 3, then random. Expect:
  - out_data stable while stalled.
  - No word lost or duplicated; the sequence equals the expected product.
  - z_addr never more than 2 ahead of the accepted word count.
- Stale done: mm_done held high from the previous job. Expect the controller still spends ≥1 cycle in WAIT and enters DRAIN only after the model's done for the new job.
- Reset mid-operation: assert reset at y word 7, then at z word 9 of a second attempt. Expect:
  - Next cycle: in_ready=1, busy=0, out_valid=0, no mm_start.
  - A fresh complete job afterwards gives the correct results.
- Back-to-back: two jobs streamed continuously. Expect in_ready to rise the cycle after the first job_done, and both result sets to be correct.
